mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store engine for the MIPS pipeline.
- Consumes the effective address computed in EX for `EXE_LW_OP`/`EXE_SW_OP`-class ops, plus store data and the 8-bit op code.
- Drives a single-outstanding SRAM-like data bus; returns aligned, extended load data.
- Stalls the pipeline while a transfer is in flight and flags address-error exceptions (AdEL/AdES) without touching the bus.

Parameters:
- ADDR_WIDTH, 32, width of addr, data_addr and bad_vaddr.

Ports:
- clk  input  1  pipeline clock
- resetn  input  1  asynchronous, active-low reset
- req_valid  input  1  MEM stage holds a valid instruction
- op  input  8  EXE_*_OP code from defines.vh
- addr  input  ADDR_WIDTH  effective byte address (ALU result)
- wdata  input  32  store data (rt)
- flush  input  1  exception/flush from CP0; kills the current op
- stall  output  1  freeze the pipeline
- load_data  output  32  extended load result
- load_valid  output  1  load_data valid (one cycle)
- adel  output  1  load address error
- ades  output  1  store address error
- bad_vaddr  output  ADDR_WIDTH  faulting address
- data_req  output  1  bus request
- data_wr  output  1  1 = write
- data_size  output  2  0 = byte, 1 = half, 2 = word
- data_addr  output  ADDR_WIDTH  byte address
- data_wdata  output  32  lane-replicated store data
- data_wstrb  output  4  byte enables
- data_addr_ok  input  1  request accepted
- data_data_ok  input  1  read data returned / write done
- data_rdata  input  32  read data

Behaviour:
- Reset: async on resetn low. State = IDLE; all outputs 0, including stall, data_req and load_valid.
- Decode:
  - mem ops are LB, LBU, LH, LHU, LW, SB, SH, SW.
  - Any other op is ignored: stall = 0, no bus activity.
- Alignment check (combinational, same cycle):
  - LH/LHU with addr[0] = 1, or LW with addr[1:0] != 0 -> adel = 1.
  - SH/SW with the same conditions -> ades = 1.
  - On error: bad_vaddr = addr, stall = 0, no request issued. adel/ades/bad_vaddr are 0 otherwise.
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE: req_valid & mem op & aligned & !flush -> register op, addr, formatted wdata, size and wstrb; go to ADDR. stall is asserted combinationally in this cycle.
  - ADDR: data_req = 1 with registered fields, held stable until data_addr_ok.
    - data_addr_ok -> DATA; data_req drops the next cycle.
    - flush before addr_ok -> IDLE; data_req deasserts next cycle and no transaction counts.
    - flush in the same cycle as addr_ok -> DATA with the kill flag set.
  - DATA: wait for data_data_ok. data_data_ok may arrive in the cycle after addr_ok at the earliest.
    - On data_data_ok with the kill flag clear -> DONE, capture formatted load_data.
    - On data_data_ok with the kill flag set -> IDLE, result discarded.
    - flush while in DATA sets the kill flag. The response is always drained because the bus cannot cancel.
  - DONE: stall = 0, load_valid = 1 for loads only (0 for stores); the pipeline advances; next state IDLE unconditionally.
- stall = 1 in IDLE on acceptance, and in ADDR and DATA when the kill flag is clear. stall = 0 in ADDR/DATA once killed, so the flush propagates.
- load_data holds its last value outside DONE.
- Store formatting:
  - SB: data_wdata = {4{wdata[7:0]}}, wstrb = 1 << addr[1:0], size 0.
  - SH: data_wdata = {2{wdata[15:0]}}, wstrb = 0011 if addr[1] = 0, else 1100; size 1.
  - SW: wdata, wstrb = 1111, size 2.
- Load formatting (little-endian lane = addr[1:0]):
  - LB: sign-extended byte; LBU: zero-extended byte.
  - LH: sign-extended half at addr[1]; LHU: zero-extended half.
  - LW: word as returned.
  - Loads drive wstrb = 0000.
- Single outstanding transaction. A new request is considered only in IDLE.
- Reset mid-transaction aborts immediately; stray data_data_ok after reset is ignored in IDLE.

Decomposition:
- Op codes (EXE_LB_OP … EXE_SW_OP) and size encodings live in defines.vh. The state encoding is local to the module.
- One combinational sub-module, mem_lane_align: store replication/wstrb generation and load extract/extend. It is shared with any future cache path.

Test Plan:
- LW addr 0x0000_1004, memory word 0x8765_4321, addr_ok after 2 cycles, data_ok 1 cycle later -> stall high 4 cycles, load_valid pulse with load_data 0x8765_4321.
- LB and LBU at addr 0x0000_1003 on word 0x80FF_0000 -> LB gives 0xFFFF_FF80, LBU gives 0x0000_0080; data_size 0.
- SH wdata 0x1234_ABCD at addr 0x0000_2002 -> data_wdata 0xABCD_ABCD, wstrb 1100, size 1, data_wr 1; load_valid stays 0.
- SW at addr 0x0000_3001 -> ades = 1, bad_vaddr 0x0000_3001, stall 0, data_req never asserted.
- LW with flush asserted in DATA, data_ok 3 cycles later -> stall drops on the flush cycle, no load_valid, FSM back to IDLE after data_ok; the next LW completes normally.
- resetn pulsed low while in ADDR -> data_req and stall go 0 immediately; a later data_data_ok is ignored.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared op codes, size encodings and decode helpers for the MEM-stage load/store engine.
package mem_access_unit_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic is_load(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load = 1'b1;
            default: is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store = 1'b1;
            default: is_store = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] op_size(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: op_size = SIZE_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: op_size = SIZE_HALF;
            default: op_size = SIZE_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] lane);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misaligned = lane[0];
            EXE_LW_OP, EXE_SW_OP: misaligned = (lane != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication/byte enables and load extract/extend.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [7:0]  st_op,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data_in,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [7:0]  ld_op,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store side: replicate data across lanes and pick byte enables; loads get no strobes.
    always_comb begin
        st_wdata = st_data_in;
        st_wstrb = 4'b0000;
        case (st_op)
            EXE_SB_OP: begin
                st_wdata = {4{st_data_in[7:0]}};
                st_wstrb = 4'b0001 << st_lane;
            end
            EXE_SH_OP: begin
                st_wdata = {2{st_data_in[15:0]}};
                st_wstrb = st_lane[1] ? 4'b1100 : 4'b0011;
            end
            EXE_SW_OP: st_wstrb = 4'b1111;
            default:   st_wstrb = 4'b0000;
        endcase
    end

    // Load side: pick the little-endian lane and extend to 32 bits.
    always_comb begin
        byte_s  = ld_rdata[{ld_lane, 3'b000} +: 8];
        half_s  = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data = ld_rdata;
        case (ld_op)
            EXE_LB_OP:  ld_data = {{24{byte_s[7]}}, byte_s};
            EXE_LBU_OP: ld_data = {24'h00_0000, byte_s};
            EXE_LH_OP:  ld_data = {{16{half_s[15]}}, half_s};
            EXE_LHU_OP: ld_data = {16'h0000, half_s};
            default:    ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: single-outstanding bus master with alignment
// exceptions and flush handling that always drains an accepted bus transfer.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    input  logic [7:0]            op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic                  flush,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  adel,
    output logic                  ades,
    output logic [ADDR_WIDTH-1:0] bad_vaddr,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [31:0]           data_wdata,
    output logic [3:0]            data_wstrb,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [31:0]           data_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [7:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [1:0]            size_q, size_d;
    logic                  wr_q, wr_d;
    logic                  kill_q, kill_d;
    logic [31:0]           load_data_q, load_data_d;

    logic        mem_op_s, mis_s, err_s, accept_s, kill_s, stall_s;
    logic [31:0] st_wdata_s, ld_data_s;
    logic [3:0]  st_wstrb_s;

    mem_lane_align u_align (
        .st_op      (op),
        .st_lane    (addr[1:0]),
        .st_data_in (wdata),
        .st_wdata   (st_wdata_s),
        .st_wstrb   (st_wstrb_s),
        .ld_op      (op_q),
        .ld_lane    (addr_q[1:0]),
        .ld_rdata   (data_rdata),
        .ld_data    (ld_data_s)
    );

    // Decode and alignment check of the instruction presented in IDLE.
    always_comb begin
        mem_op_s = is_load(op) | is_store(op);
        mis_s    = misaligned(op, addr[1:0]);
        err_s    = (state_q == S_IDLE) & req_valid & mem_op_s & mis_s;
        accept_s = (state_q == S_IDLE) & req_valid & mem_op_s & ~mis_s & ~flush;
    end

    // Next-state and captured-field logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        size_d      = size_q;
        wr_d        = wr_q;
        kill_d      = kill_q;
        load_data_d = load_data_q;
        kill_s      = kill_q | flush;
        stall_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_ADDR;
                    op_d    = op;
                    addr_d  = addr;
                    wdata_d = st_wdata_s;
                    wstrb_d = st_wstrb_s;
                    size_d  = op_size(op);
                    wr_d    = is_store(op);
                    kill_d  = 1'b0;
                    stall_s = 1'b1;
                end else begin
                    stall_s = 1'b0;
                end
            end
            S_ADDR: begin
                stall_s = ~flush;
                if (data_addr_ok) begin
                    state_d = S_DATA;
                    kill_d  = flush;
                end else if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ADDR;
                end
            end
            // The bus cannot cancel, so a killed transfer still waits for its response.
            S_DATA: begin
                stall_s = ~kill_s;
                kill_d  = kill_s;
                if (data_data_ok) begin
                    kill_d = 1'b0;
                    if (kill_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        if (!wr_q) begin
                            load_data_d = ld_data_s;
                        end else begin
                            load_data_d = load_data_q;
                        end
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-field registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            op_q        <= 8'h00;
            addr_q      <= {ADDR_WIDTH{1'b0}};
            wdata_q     <= 32'h0000_0000;
            wstrb_q     <= 4'b0000;
            size_q      <= 2'b00;
            wr_q        <= 1'b0;
            kill_q      <= 1'b0;
            load_data_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            size_q      <= size_d;
            wr_q        <= wr_d;
            kill_q      <= kill_d;
            load_data_q <= load_data_d;
        end
    end

    assign stall      = stall_s;
    assign adel       = err_s & is_load(op);
    assign ades       = err_s & is_store(op);
    assign bad_vaddr  = err_s ? addr : {ADDR_WIDTH{1'b0}};
    assign load_data  = load_data_q;
    assign load_valid = (state_q == S_DONE) & ~wr_q;
    assign data_req   = (state_q == S_ADDR);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign data_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a hand-driven data bus.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        adel;
    logic        ades;
    logic [31:0] bad_vaddr;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    int          res_stall, res_lv, res_req, res_done;
    logic [31:0] res_ld, cap_wdata, cap_addr;
    logic [3:0]  cap_wstrb;
    logic [1:0]  cap_size;
    logic        cap_wr;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .op           (op),
        .addr         (addr),
        .wdata        (wdata),
        .flush        (flush),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .adel         (adel),
        .ades         (ades),
        .bad_vaddr    (bad_vaddr),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer: addr_ok after aw extra ADDR cycles, data_ok after dw extra DATA cycles.
    task automatic xfer(input logic [7:0] t_op, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                        input int aw, input int dw, input logic [31:0] t_rdata);
        int wa = 0;
        int wd = 0;
        bit in_data = 1'b0;
        bit nxt = 1'b0;
        res_stall = 0; res_lv = 0; res_req = 0; res_done = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; op = t_op; addr = t_addr; wdata = t_wdata;
        for (int k = 0; k < 40; k++) begin
            data_addr_ok = 1'b0; data_data_ok = 1'b0; in_data = nxt;
            #1;
            if (data_req) begin
                res_req++;
                if (wa == aw) begin
                    data_addr_ok = 1'b1;
                    cap_wdata = data_wdata; cap_wstrb = data_wstrb; cap_size = data_size;
                    cap_wr = data_wr; cap_addr = data_addr;
                    nxt = 1'b1;
                end else wa++;
            end else if (in_data) begin
                if (wd == dw) begin
                    data_data_ok = 1'b1; data_rdata = t_rdata; nxt = 1'b0;
                end else wd++;
            end
            #1;
            if (stall) res_stall++;
            if (load_valid) begin res_lv++; res_ld = load_data; end
            if (!stall) begin
                res_done = (k > 0) ? 1 : 0;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; op = 8'h00; addr = 32'h0; wdata = 32'h0;
        flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_lv", {31'd0, load_valid}, 32'd0);
        chk("rst_ld", load_data, 32'h0);
        chk("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
        resetn = 1'b1;

        // LW: addr_ok on the 2nd ADDR cycle, data_ok right after.
        xfer(EXE_LW_OP, 32'h0000_1004, 32'h0, 1, 0, 32'h8765_4321);
        chk("lw_done", res_done, 32'd1);
        chk("lw_stall_cycles", res_stall, 32'd4);
        chk("lw_req_cycles", res_req, 32'd2);
        chk("lw_lv", res_lv, 32'd1);
        chk("lw_data", res_ld, 32'h8765_4321);
        chk("lw_addr", cap_addr, 32'h0000_1004);
        chk("lw_size", {30'd0, cap_size}, 32'd2);
        chk("lw_wstrb", {28'd0, cap_wstrb}, 32'd0);
        chk("lw_wr", {31'd0, cap_wr}, 32'd0);
        chk("lw_after_lv", {31'd0, load_valid}, 32'd0);
        chk("lw_hold", load_data, 32'h8765_4321);

        xfer(EXE_LB_OP, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_0000);
        chk("lb_data", res_ld, 32'hFFFF_FF80);
        chk("lb_size", {30'd0, cap_size}, 32'd0);
        chk("lb_stall_cycles", res_stall, 32'd3);
        xfer(EXE_LBU_OP, 32'h0000_1003, 32'h0, 0, 1, 32'h80FF_0000);
        chk("lbu_data", res_ld, 32'h0000_0080);
        chk("lbu_size", {30'd0, cap_size}, 32'd0);
        xfer(EXE_LH_OP, 32'h0000_1002, 32'h0, 0, 0, 32'h8001_7FFF);
        chk("lh_data", res_ld, 32'hFFFF_8001);
        chk("lh_size", {30'd0, cap_size}, 32'd1);
        xfer(EXE_LHU_OP, 32'h0000_1000, 32'h0, 2, 0, 32'h8001_F00F);
        chk("lhu_data", res_ld, 32'h0000_F00F);

        xfer(EXE_SH_OP, 32'h0000_2002, 32'h1234_ABCD, 0, 0, 32'h0);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_wstrb", {28'd0, cap_wstrb}, 32'hC);
        chk("sh_size", {30'd0, cap_size}, 32'd1);
        chk("sh_wr", {31'd0, cap_wr}, 32'd1);
        chk("sh_lv", res_lv, 32'd0);
        chk("sh_done", res_done, 32'd1);
        chk("sh_ld_hold", load_data, 32'h0000_F00F);
        xfer(EXE_SB_OP, 32'h0000_2001, 32'h0000_00EF, 0, 0, 32'h0);
        chk("sb_wdata", cap_wdata, 32'hEFEF_EFEF);
        chk("sb_wstrb", {28'd0, cap_wstrb}, 32'h2);
        xfer(EXE_SW_OP, 32'h0000_2004, 32'hCAFE_0123, 0, 1, 32'h0);
        chk("sw_wdata", cap_wdata, 32'hCAFE_0123);
        chk("sw_wstrb", {28'd0, cap_wstrb}, 32'hF);
        chk("sw_size", {30'd0, cap_size}, 32'd2);

        // Misaligned store and loads raise exceptions without touching the bus.
        @(posedge clk); #1;
        req_valid = 1'b1; op = EXE_SW_OP; addr = 32'h0000_3001; wdata = 32'h1;
        #1;
        chk("ades_flag", {31'd0, ades}, 32'd1);
        chk("ades_adel", {31'd0, adel}, 32'd0);
        chk("ades_vaddr", bad_vaddr, 32'h0000_3001);
        chk("ades_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #2;
        chk("ades_no_req", {31'd0, data_req}, 32'd0);
        op = EXE_LW_OP; addr = 32'h0000_1002; #1;
        chk("adel_lw", {31'd0, adel}, 32'd1);
        chk("adel_lw_vaddr", bad_vaddr, 32'h0000_1002);
        op = EXE_LH_OP; addr = 32'h0000_1001; #1;
        chk("adel_lh", {31'd0, adel}, 32'd1);
        op = EXE_LH_OP; addr = 32'h0000_1002; req_valid = 1'b0; #1;
        chk("noerr_adel", {31'd0, adel}, 32'd0);
        chk("noerr_vaddr", bad_vaddr, 32'h0);

        // Non-memory op is ignored.
        @(posedge clk); #1;
        req_valid = 1'b1; op = 8'h25; addr = 32'h0000_1000; #1;
        chk("nonmem_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #2;
        chk("nonmem_req", {31'd0, data_req}, 32'd0);
        req_valid = 1'b0;

        // Flush during DATA: stall drops, response drained, no load_valid.
        @(posedge clk); #1;
        req_valid = 1'b1; op = EXE_LW_OP; addr = 32'h0000_1008; #1;
        chk("fl_accept_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        data_addr_ok = 1'b1; #1;
        chk("fl_addr_req", {31'd0, data_req}, 32'd1);
        @(posedge clk); #1;
        data_addr_ok = 1'b0; #1;
        chk("fl_data_stall", {31'd0, stall}, 32'd1);
        flush = 1'b1; #1;
        chk("fl_flush_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0; #1;
        chk("fl_killed_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; #1;
        chk("fl_dok_lv", {31'd0, load_valid}, 32'd0);
        @(posedge clk); #1;
        data_data_ok = 1'b0; #1;
        chk("fl_no_lv", {31'd0, load_valid}, 32'd0);
        chk("fl_ld_hold", load_data, 32'h0000_F00F);
        chk("fl_idle_req", {31'd0, data_req}, 32'd0);
        xfer(EXE_LW_OP, 32'h0000_100C, 32'h0, 0, 0, 32'hCAFE_F00D);
        chk("fl_next_done", res_done, 32'd1);
        chk("fl_next_data", res_ld, 32'hCAFE_F00D);
        chk("fl_next_lv", res_lv, 32'd1);

        // Reset while in ADDR aborts immediately; a stray data_ok is ignored.
        @(posedge clk); #1;
        req_valid = 1'b1; op = EXE_LW_OP; addr = 32'h0000_2000;
        @(posedge clk); #1;
        chk("rs_addr_req", {31'd0, data_req}, 32'd1);
        resetn = 1'b0; req_valid = 1'b0; #1;
        chk("rs_req_drop", {31'd0, data_req}, 32'd0);
        chk("rs_stall_drop", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        data_data_ok = 1'b1; data_rdata = 32'h1111_2222; #1;
        chk("rs_stray_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        data_data_ok = 1'b0; #1;
        chk("rs_stray_lv", {31'd0, load_valid}, 32'd0);
        chk("rs_stray_req", {31'd0, data_req}, 32'd0);
        chk("rs_ld_cleared", load_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
